lstm_array_sequencer: RTL and testbench

Top-level sequencer for one LSTM layer pass through the systolic array. Generates the divided PE clock, pulses the array/output-buffer `start`, times the compute window from the array geometry, then hands the result to the LSTM cell via `start_load_cell` and waits for load completion. Repeats for a programmable number of time steps. Sits in `sys_top` between the host/control interface and the output buffer, input buffer and LSTM cell.

---
 rtl/lstm_array_sequencer_pkg.sv | 18 +
 rtl/lstm_array_sequencer_if.sv | 33 +++
 rtl/lstm_array_sequencer_pe_clk_div.sv | 44 ++++
 rtl/lstm_array_sequencer.sv | 137 +++++++++++++
 tb/tb_lstm_array_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lstm_array_sequencer_pkg.sv
// lstm_seq_pkg: shared types and geometry helpers for the LSTM array sequencer.
//   seq_state_t    - sequencer FSM states
//   compute_ticks  - pe ticks in one compute window (GAMMA*M + P)
package lstm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPUTE   = 2'd1,
    WAIT_CELL = 2'd2,
    LOAD      = 2'd3
  } seq_state_t;

  // GAMMA passes of M elements, plus P ticks to drain the PE pipeline.
  function automatic int compute_ticks(input int gamma, input int m, input int p);
    return gamma * m + p;
  endfunction

endpackage

// File: rtl/lstm_array_sequencer_if.sv
// lstm_array_sequencer_if: control/handshake bundle between host, array,
// output buffer, LSTM cell and the sequencer.
//   master : drives go/num_steps/abort/cell_ready/load_done, observes status
//   slave  : the sequencer itself
interface lstm_array_sequencer_if #(
  parameter int STEP_BITS = 8
);
  logic                 go;
  logic [STEP_BITS-1:0] num_steps;
  logic                 abort;
  logic                 cell_ready;
  logic                 load_done;
  logic                 pe_clk;
  logic                 array_start;
  logic                 start_load_cell;
  logic                 busy;
  logic                 step_done;
  logic                 seq_done;
  logic                 error;
  logic [STEP_BITS-1:0] step_idx;

  modport master (
    output go, num_steps, abort, cell_ready, load_done,
    input  pe_clk, array_start, start_load_cell, busy, step_done, seq_done,
           error, step_idx
  );

  modport slave (
    input  go, num_steps, abort, cell_ready, load_done,
    output pe_clk, array_start, start_load_cell, busy, step_done, seq_done,
           error, step_idx
  );
endinterface

// File: rtl/lstm_array_sequencer_pe_clk_div.sv
// pe_clk_div: divides sys_clk by MUL_LAT to make the PE clock.
//   sys_clk, reset : clock / async active-high reset
//   run            : divider counts while high, else held at 0 with pe_clk low
//   restart        : restart the period (counter 0, pe_clk high) this edge
//   pe_clk         : registered divided clock, high for the first half period
//   pe_tick        : high in the last sys_clk cycle of each pe period
module pe_clk_div #(
  parameter int MUL_LAT = 4
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic pe_clk,
  output logic pe_tick
);
  localparam int CW = $clog2(MUL_LAT);
  localparam logic [CW-1:0] LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] HALF = CW'(MUL_LAT / 2);

  logic [CW-1:0] r_cnt;
  logic          r_pe_clk;
  logic [CW-1:0] w_cnt_nxt;

  assign w_cnt_nxt = (restart || r_cnt == LAST) ? '0 : r_cnt + 1'b1;

  // pe_clk is registered from the next count so it is glitch-free and
  // already high in the first cycle of a period.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_pe_clk <= 1'b0;
    end else if (!run) begin
      r_cnt    <= '0;
      r_pe_clk <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_pe_clk <= (w_cnt_nxt < HALF);
    end
  end

  assign pe_clk  = r_pe_clk;
  assign pe_tick = (r_cnt == LAST);
endmodule

// File: rtl/lstm_array_sequencer.sv
// lstm_array_sequencer: runs num_steps LSTM time steps through the systolic
// array: compute window (timed in pe ticks), wait for the cell, load, repeat.
//   sys_clk, reset : clock / async active-high reset
//   bus (slave)    : go/num_steps/abort/cell_ready/load_done in;
//                    pe_clk, array_start, start_load_cell, busy, step_done,
//                    seq_done, error, step_idx out (all registered)
module lstm_array_sequencer
  import lstm_seq_pkg::*;
#(
  parameter int MUL_LAT      = 4,
  parameter int P            = 4,
  parameter int M            = 9,
  parameter int GAMMA        = 3,
  parameter int STEP_BITS    = 8,
  parameter int LOAD_TIMEOUT = 32
) (
  input logic                   sys_clk,
  input logic                   reset,
  lstm_array_sequencer_if.slave bus
);
  localparam int CT = compute_ticks(GAMMA, M, P);
  localparam int TW = $clog2(CT + 1);
  localparam int LW = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CT - 1);
  localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_TIMEOUT - 1);

  seq_state_t           r_state, w_nxt;
  logic [TW-1:0]        r_tick;
  logic [LW-1:0]        r_load_cnt;
  logic [STEP_BITS-1:0] r_num, r_step_idx, w_idx_inc;
  logic r_array_start, r_start_load, r_busy, r_step_done, r_seq_done, r_error;
  logic w_go_ok, w_zero_go, w_step, w_last, w_tout;
  logic w_run, w_restart, w_pe_tick;

  assign w_idx_inc = r_step_idx + 1'b1;

  always_comb begin
    w_nxt     = r_state;
    w_go_ok   = 1'b0;
    w_zero_go = 1'b0;
    w_step    = 1'b0;
    w_last    = 1'b0;
    w_tout    = 1'b0;
    if (bus.abort) begin
      w_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:
          if (bus.go) begin
            if (bus.num_steps == '0) w_zero_go = 1'b1;
            else begin
              w_go_ok = 1'b1;
              w_nxt   = COMPUTE;
            end
          end
        COMPUTE:
          if (w_pe_tick && r_tick == TICK_LAST) w_nxt = WAIT_CELL;
        WAIT_CELL:
          if (bus.cell_ready) w_nxt = LOAD;
        LOAD:
          if (bus.load_done) begin
            w_step = 1'b1;
            if (w_idx_inc == r_num) begin
              w_last = 1'b1;
              w_nxt  = IDLE;
            end else begin
              w_nxt = COMPUTE;
            end
          end else if (r_load_cnt == LOAD_LAST) begin
            w_tout = 1'b1;
            w_nxt  = IDLE;
          end
        default: w_nxt = IDLE;
      endcase
    end
  end

  // Divider runs only while the next state is COMPUTE; every COMPUTE entry
  // restarts it so array_start lines up with a fresh pe_clk rising phase.
  assign w_run     = (w_nxt == COMPUTE);
  assign w_restart = w_run && (r_state != COMPUTE);

  pe_clk_div #(.MUL_LAT(MUL_LAT)) u_div (
    .sys_clk (sys_clk),
    .reset   (reset),
    .run     (w_run),
    .restart (w_restart),
    .pe_clk  (bus.pe_clk),
    .pe_tick (w_pe_tick)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_tick        <= '0;
      r_load_cnt    <= '0;
      r_num         <= '0;
      r_step_idx    <= '0;
      r_array_start <= 1'b0;
      r_start_load  <= 1'b0;
      r_busy        <= 1'b0;
      r_step_done   <= 1'b0;
      r_seq_done    <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_state       <= w_nxt;
      r_busy        <= (w_nxt != IDLE);
      r_array_start <= w_restart;
      r_start_load  <= (w_nxt == LOAD) && (r_state != LOAD);
      r_step_done   <= w_step;
      r_seq_done    <= w_last || w_zero_go;
      // counters restart on every entry into their state
      if (r_state == COMPUTE && w_nxt == COMPUTE) begin
        if (w_pe_tick) r_tick <= r_tick + 1'b1;
      end else begin
        r_tick <= '0;
      end
      r_load_cnt <= (r_state == LOAD && w_nxt == LOAD) ? r_load_cnt + 1'b1 : '0;
      if (w_go_ok) begin
        r_num      <= bus.num_steps;
        r_step_idx <= '0;
      end else if (w_step) begin
        r_step_idx <= w_idx_inc;
      end
      if (w_go_ok || w_zero_go) r_error <= 1'b0;
      else if (w_tout)          r_error <= 1'b1;
    end
  end

  assign bus.array_start     = r_array_start;
  assign bus.start_load_cell = r_start_load;
  assign bus.busy            = r_busy;
  assign bus.step_done       = r_step_done;
  assign bus.seq_done        = r_seq_done;
  assign bus.error           = r_error;
  assign bus.step_idx        = r_step_idx;
endmodule

// File: tb/tb_lstm_array_sequencer.sv
// Scoreboard bench: stimulus pushes expected event cycles per output pulse,
// a negedge monitor pops and compares; a second instance with MUL_LAT=2
// covers the fastest divider.
module tb_lstm_array_sequencer;
  localparam int ML = 4, PP = 4, MM = 9, GG = 3, SB = 8, LT = 32;
  localparam int T  = (GG * MM + PP) * ML;   // compute window in sys_clk cycles

  typedef struct { int cyc; int idx; } step_exp_t;

  logic clk = 1'b0, rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  int   q_arr[$], q_slc[$], q_seq[$], q_err[$];
  step_exp_t q_step[$];
  int   pe_s = 0, pe_e = 0;
  logic err_prev = 1'b0;
  int   crd_t[4], ld_t[4];

  lstm_array_sequencer_if #(.STEP_BITS(SB)) bus ();
  lstm_array_sequencer_if #(.STEP_BITS(SB)) bus2 ();

  lstm_array_sequencer #(.MUL_LAT(ML), .P(PP), .M(MM), .GAMMA(GG),
    .STEP_BITS(SB), .LOAD_TIMEOUT(LT)) dut (.sys_clk(clk), .reset(rst), .bus(bus));
  lstm_array_sequencer #(.MUL_LAT(2), .P(PP), .M(MM), .GAMMA(GG),
    .STEP_BITS(SB), .LOAD_TIMEOUT(LT)) dut2 (.sys_clk(clk), .reset(rst), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic unexp(input string nm);
    n_chk++;
    $display("FAIL %s: unexpected pulse at cycle %0d", nm, cyc);
  endtask

  task automatic wait_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // monitor: every pulse must match the head of its expectation queue
  always @(negedge clk) begin
    if (rst) err_prev = 1'b0;
    else begin
      if (bus.array_start) begin
        if (q_arr.size() == 0) unexp("array_start"); else chk("array_start_cyc", cyc, q_arr.pop_front());
      end
      if (bus.start_load_cell) begin
        if (q_slc.size() == 0) unexp("start_load_cell"); else chk("start_load_cyc", cyc, q_slc.pop_front());
      end
      if (bus.step_done) begin
        if (q_step.size() == 0) unexp("step_done");
        else begin
          step_exp_t e;
          e = q_step.pop_front();
          chk("step_done_cyc", cyc, e.cyc);
          chk("step_done_idx", bus.step_idx, e.idx);
        end
      end
      if (bus.seq_done) begin
        if (q_seq.size() == 0) unexp("seq_done"); else chk("seq_done_cyc", cyc, q_seq.pop_front());
      end
      if (bus.error && !err_prev) begin
        if (q_err.size() == 0) unexp("error"); else chk("error_rise_cyc", cyc, q_err.pop_front());
      end
      err_prev = bus.error;
      chk("pe_clk", bus.pe_clk,
          (cyc >= pe_s && cyc < pe_e) ? 32'(((cyc - pe_s) % ML) < ML / 2) : 32'd0);
    end
  end

  // crd<0: cell_ready already high; else raised crd cycles into WAIT_CELL.
  // ld<0: never send load_done (timeout).
  task automatic do_step(input int s, input int crd, input int ld, input bit last,
                         input int idx, input bit inj, output int ns);
    int w, l;
    step_exp_t e;
    ns = -1;
    w  = s + T;
    q_arr.push_back(s);
    pe_s = s; pe_e = w;
    bus.cell_ready = (crd < 0);
    if (inj) begin
      wait_cycle(s + 10); bus.go = 1'b1; bus.num_steps = 8'd99;
      wait_cycle(s + 11); bus.go = 1'b0;
    end
    if (crd < 0) l = w + 1;
    else begin
      wait_cycle(w + crd); bus.cell_ready = 1'b1; l = w + crd + 1;
    end
    q_slc.push_back(l);
    wait_cycle(l);
    bus.cell_ready = 1'b0;
    if (ld < 0) begin
      q_err.push_back(l + LT);
      wait_cycle(l + LT);
      chk("timeout_busy", bus.busy, 0);
      chk("timeout_error", bus.error, 1);
      return;
    end
    e.cyc = l + ld + 1; e.idx = idx;
    q_step.push_back(e);
    if (last) q_seq.push_back(l + ld + 1);
    wait_cycle(l + ld); bus.load_done = 1'b1;
    wait_cycle(l + ld + 1); bus.load_done = 1'b0;
    chk("step_idx_after", bus.step_idx, idx);
    chk("busy_after_step", bus.busy, {31'd0, !last});
    if (!last) ns = l + ld + 1;
  endtask

  task automatic run_seq(input int n, input int inj);
    int g, s, ns;
    g = cyc;
    bus.go = 1'b1; bus.num_steps = SB'(n);
    wait_cycle(g + 1);
    bus.go = 1'b0;
    chk("go_busy", bus.busy, 1);
    chk("go_error_clr", bus.error, 0);
    chk("go_idx_clr", bus.step_idx, 0);
    s = g + 1;
    for (int i = 0; i < n; i++) begin
      do_step(s, crd_t[i], ld_t[i], i == n - 1, i + 1, i == inj, ns);
      if (ns < 0) break;
      s = ns;
    end
    wait_cycle(cyc + 3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, s, ns, l;
    bus.go = 0; bus.num_steps = 0; bus.abort = 0; bus.cell_ready = 0; bus.load_done = 0;
    bus2.go = 0; bus2.num_steps = 0; bus2.abort = 0; bus2.cell_ready = 0; bus2.load_done = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pe_clk", bus.pe_clk, 0);     chk("rst_array_start", bus.array_start, 0);
    chk("rst_start_load", bus.start_load_cell, 0); chk("rst_busy", bus.busy, 0);
    chk("rst_step_done", bus.step_done, 0); chk("rst_seq_done", bus.seq_done, 0);
    chk("rst_error", bus.error, 0);       chk("rst_step_idx", bus.step_idx, 0);
    rst = 1'b0;
    wait_cycle(cyc + 2);

    // single step, cell ready early, load_done 5 cycles after start_load_cell
    crd_t[0] = -1; ld_t[0] = 5;
    run_seq(1, -1);
    // three steps, load_done same cycle as start_load_cell / at last legal cycle,
    // stray go during step 2
    crd_t[0] = 0; ld_t[0] = 0; crd_t[1] = 3; ld_t[1] = 31; crd_t[2] = -1; ld_t[2] = 7;
    run_seq(3, 1);
    // cell_ready held off 50 cycles
    crd_t[0] = 50; ld_t[0] = 2;
    run_seq(1, -1);
    // load timeout, then a fresh go clears error
    crd_t[0] = 0; ld_t[0] = -1;
    run_seq(1, -1);
    crd_t[0] = 1; ld_t[0] = 4;
    run_seq(1, -1);

    // abort in the middle of step 2 compute
    g = cyc;
    bus.go = 1'b1; bus.num_steps = 8'd3;
    wait_cycle(g + 1); bus.go = 1'b0;
    do_step(g + 1, -1, 3, 1'b0, 1, 1'b0, ns);
    s = ns;
    q_arr.push_back(s); pe_s = s; pe_e = s + T;
    wait_cycle(s + 40); bus.abort = 1'b1; pe_e = s + 41;
    wait_cycle(s + 41); bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_idx_hold", bus.step_idx, 1);
    bus.cell_ready = 1'b1; bus.load_done = 1'b1;   // ignored in IDLE
    wait_cycle(cyc + 2);
    bus.cell_ready = 1'b0; bus.load_done = 1'b0;
    wait_cycle(cyc + 3);

    // asynchronous reset in the middle of LOAD
    g = cyc;
    bus.go = 1'b1; bus.num_steps = 8'd2;
    wait_cycle(g + 1); bus.go = 1'b0;
    s = g + 1;
    q_arr.push_back(s); pe_s = s; pe_e = s + T;
    bus.cell_ready = 1'b1;
    l = s + T + 1;
    q_slc.push_back(l);
    wait_cycle(l + 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);       chk("arst_pe_clk", bus.pe_clk, 0);
    chk("arst_start_load", bus.start_load_cell, 0); chk("arst_step_done", bus.step_done, 0);
    chk("arst_step_idx", bus.step_idx, 0);
    bus.cell_ready = 1'b0;
    wait_cycle(l + 6);
    rst = 1'b0;
    wait_cycle(cyc + 2);

    // go with zero steps: seq_done only
    g = cyc;
    bus.go = 1'b1; bus.num_steps = 8'd0;
    q_seq.push_back(g + 1);
    wait_cycle(g + 1); bus.go = 1'b0;
    chk("zero_go_busy", bus.busy, 0);
    wait_cycle(cyc + 3);

    // randomized sequences
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) begin
        crd_t[i] = int'($urandom_range(0, 9)) - 1;
        ld_t[i]  = $urandom_range(0, 31);
      end
      run_seq(n, -1);
    end

    // MUL_LAT=2 instance: pe_clk toggles every cycle, COMPUTE is 62 cycles
    g = cyc;
    bus2.go = 1'b1; bus2.num_steps = 8'd1; bus2.cell_ready = 1'b1;
    wait_cycle(g + 1); bus2.go = 1'b0;
    s = g + 1;
    chk("ml2_array_start", bus2.array_start, 1);
    for (int c = 0; c < 62; c++) begin
      wait_cycle(s + c);
      chk("ml2_pe_clk", bus2.pe_clk, {31'd0, (c % 2) == 0});
    end
    wait_cycle(s + 62);
    chk("ml2_wait_pe_clk", bus2.pe_clk, 0);
    chk("ml2_wait_busy", bus2.busy, 1);
    chk("ml2_wait_no_load", bus2.start_load_cell, 0);
    wait_cycle(s + 63);
    chk("ml2_start_load", bus2.start_load_cell, 1);
    bus2.load_done = 1'b1; bus2.cell_ready = 1'b0;
    wait_cycle(s + 64);
    bus2.load_done = 1'b0;
    chk("ml2_step_done", bus2.step_done, 1);
    chk("ml2_seq_done", bus2.seq_done, 1);
    chk("ml2_busy_drop", bus2.busy, 0);
    chk("ml2_step_idx", bus2.step_idx, 1);

    wait_cycle(cyc + 5);
    chk("drain_arr", q_arr.size(), 0);  chk("drain_slc", q_slc.size(), 0);
    chk("drain_step", q_step.size(), 0); chk("drain_seq", q_seq.size(), 0);
    chk("drain_err", q_err.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
